// File: rtl/sw_core_affine.sv
// sw_core_affine: Smith-Waterman local-alignment core with affine gap penalties.
// One DP cell is computed per clock in a row-major sweep (read rows, ref columns).
// The core returns the best local score and the 0-based row/column of its first occurrence.
// Optional feature macro: SW_CYCLE_COUNT_EN adds o_cycle_count (WORK cycles of the current job).
module sw_core_affine #(
    parameter int REF_MAX_LEN  = 128,
    parameter int READ_MAX_LEN = 128,
    parameter int SCORE_W      = 10,
    parameter int MATCH        = 1,
    parameter int MISMATCH     = -4,
    parameter int GAP_OPEN     = -6,
    parameter int GAP_EXTEND   = -1
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic                                o_ready,
    input  logic                                i_valid,
    input  logic [2*REF_MAX_LEN-1:0]            i_sequence_ref,
    input  logic [2*READ_MAX_LEN-1:0]           i_sequence_read,
    input  logic [$clog2(REF_MAX_LEN):0]        i_seq_ref_length,
    input  logic [$clog2(READ_MAX_LEN):0]       i_seq_read_length,
    input  logic                                i_ready,
    output logic                                o_valid,
    output logic signed [SCORE_W-1:0]           o_alignment_score,
    output logic [$clog2(REF_MAX_LEN)-1:0]      o_column,
    output logic [$clog2(READ_MAX_LEN)-1:0]     o_row
`ifdef SW_CYCLE_COUNT_EN
    ,
    output logic [31:0]                         o_cycle_count
`endif
);

    localparam int QL_W  = $clog2(REF_MAX_LEN) + 1;
    localparam int RL_W  = $clog2(READ_MAX_LEN) + 1;
    localparam int COL_W = $clog2(REF_MAX_LEN);
    localparam int ROW_W = $clog2(READ_MAX_LEN);

    localparam logic signed [SCORE_W-1:0] NEG_INF    = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic signed [SCORE_W-1:0] POS_MAX    = {1'b0, {(SCORE_W-1){1'b1}}};
    localparam logic signed [SCORE_W-1:0] ZERO_S     = {SCORE_W{1'b0}};
    localparam logic signed [SCORE_W-1:0] MATCH_S    = SCORE_W'(MATCH);
    localparam logic signed [SCORE_W-1:0] MISMATCH_S = SCORE_W'(MISMATCH);
    localparam logic signed [SCORE_W-1:0] GO_S       = SCORE_W'(GAP_OPEN);
    localparam logic signed [SCORE_W-1:0] GE_S       = SCORE_W'(GAP_EXTEND);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WORK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Add at one extra bit and clamp to the representable score range.
    function automatic logic signed [SCORE_W-1:0] sat_add(
        input logic signed [SCORE_W-1:0] a,
        input logic signed [SCORE_W-1:0] b
    );
        logic signed [SCORE_W:0] sum;
        sum = $signed({a[SCORE_W-1], a}) + $signed({b[SCORE_W-1], b});
        if (sum[SCORE_W] != sum[SCORE_W-1]) begin
            sat_add = sum[SCORE_W] ? NEG_INF : POS_MAX;
        end else begin
            sat_add = sum[SCORE_W-1:0];
        end
    endfunction

    function automatic logic signed [SCORE_W-1:0] smax(
        input logic signed [SCORE_W-1:0] a,
        input logic signed [SCORE_W-1:0] b
    );
        if (a > b) begin
            smax = a;
        end else begin
            smax = b;
        end
    endfunction

    state_t r_state;
    state_t w_next_state;

    logic                        r_ready;
    logic                        r_valid;
    logic [2*REF_MAX_LEN-1:0]    r_ref;
    logic [2*READ_MAX_LEN-1:0]   r_read;
    logic [QL_W-1:0]             r_q;
    logic [RL_W-1:0]             r_r;
    logic [COL_W-1:0]            r_col;
    logic [ROW_W-1:0]            r_row;
    logic signed [SCORE_W-1:0]   r_diag;
    logic signed [SCORE_W-1:0]   r_left_h;
    logic signed [SCORE_W-1:0]   r_left_e;
    logic signed [SCORE_W-1:0]   r_best;
    logic [COL_W-1:0]            r_best_col;
    logic [ROW_W-1:0]            r_best_row;
    logic signed [SCORE_W-1:0]   r_h_row [REF_MAX_LEN];
    logic signed [SCORE_W-1:0]   r_f_row [REF_MAX_LEN];

    logic                        w_accept;
    logic [QL_W-1:0]             w_q_in;
    logic [RL_W-1:0]             w_r_in;
    logic                        w_last_col;
    logic                        w_last_cell;
    logic [1:0]                  w_ref_base;
    logic [1:0]                  w_read_base;
    logic signed [SCORE_W-1:0]   w_h_up;
    logic signed [SCORE_W-1:0]   w_f_up;
    logic signed [SCORE_W-1:0]   w_diag;
    logic signed [SCORE_W-1:0]   w_left_h;
    logic signed [SCORE_W-1:0]   w_left_e;
    logic signed [SCORE_W-1:0]   w_s;
    logic signed [SCORE_W-1:0]   w_e;
    logic signed [SCORE_W-1:0]   w_f;
    logic signed [SCORE_W-1:0]   w_h;

    assign o_ready           = r_ready;
    assign o_valid           = r_valid;
    assign o_alignment_score = r_best;
    assign o_column          = r_best_col;
    assign o_row             = r_best_row;

    assign w_accept = (r_state == ST_IDLE) && i_valid && r_ready;

    // Clamp offered lengths to the buffer capacity.
    always_comb begin
        if (i_seq_ref_length > QL_W'(REF_MAX_LEN)) begin
            w_q_in = QL_W'(REF_MAX_LEN);
        end else begin
            w_q_in = i_seq_ref_length;
        end
        if (i_seq_read_length > RL_W'(READ_MAX_LEN)) begin
            w_r_in = RL_W'(READ_MAX_LEN);
        end else begin
            w_r_in = i_seq_read_length;
        end
    end

    // Cell neighbours: first row/column fall back to the DP boundary values.
    always_comb begin
        w_last_col  = ((QL_W'(r_col) + QL_W'(1)) == r_q);
        w_last_cell = w_last_col && ((RL_W'(r_row) + RL_W'(1)) == r_r);
        w_ref_base  = r_ref[{r_col, 1'b0} +: 2];
        w_read_base = r_read[{r_row, 1'b0} +: 2];
        if (r_row == {ROW_W{1'b0}}) begin
            w_h_up = ZERO_S;
            w_f_up = NEG_INF;
        end else begin
            w_h_up = r_h_row[r_col];
            w_f_up = r_f_row[r_col];
        end
        if (r_col == {COL_W{1'b0}}) begin
            w_diag   = ZERO_S;
            w_left_h = ZERO_S;
            w_left_e = NEG_INF;
        end else begin
            w_diag   = r_diag;
            w_left_h = r_left_h;
            w_left_e = r_left_e;
        end
    end

    // Affine-gap recurrences for the current cell.
    always_comb begin
        if (w_ref_base == w_read_base) begin
            w_s = MATCH_S;
        end else begin
            w_s = MISMATCH_S;
        end
        w_e = smax(sat_add(w_left_h, GO_S), sat_add(w_left_e, GE_S));
        w_f = smax(sat_add(w_h_up, GO_S), sat_add(w_f_up, GE_S));
        w_h = smax(smax(ZERO_S, sat_add(w_diag, w_s)), smax(w_e, w_f));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: empty jobs skip straight to DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if ((w_q_in == {QL_W{1'b0}}) || (w_r_in == {RL_W{1'b0}})) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_WORK;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WORK: begin
                if (w_last_cell) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_WORK;
                end
            end
            ST_DONE: begin
                if (r_valid && i_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs; o_valid rises one cycle after DONE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_ready <= (w_next_state == ST_IDLE);
            r_valid <= (r_state == ST_DONE) && !(r_valid && i_ready);
        end
    end

    // Job capture, sweep indices, neighbour registers and best-cell tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref      <= '0;
            r_read     <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_diag     <= ZERO_S;
            r_left_h   <= ZERO_S;
            r_left_e   <= NEG_INF;
            r_best     <= ZERO_S;
            r_best_col <= '0;
            r_best_row <= '0;
        end else if (w_accept) begin
            r_ref      <= i_sequence_ref;
            r_read     <= i_sequence_read;
            r_q        <= w_q_in;
            r_r        <= w_r_in;
            r_col      <= '0;
            r_row      <= '0;
            r_best     <= ZERO_S;
            r_best_col <= '0;
            r_best_row <= '0;
        end else if (r_state == ST_WORK) begin
            r_diag   <= w_h_up;
            r_left_h <= w_h;
            r_left_e <= w_e;
            if (w_h > r_best) begin
                r_best     <= w_h;
                r_best_col <= r_col;
                r_best_row <= r_row;
            end else begin
                r_best     <= r_best;
            end
            if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end else begin
            r_col <= r_col;
        end
    end

    // Previous-row H and F buffers; rows beyond the first overwrite in place.
    always_ff @(posedge clk) begin
        if (r_state == ST_WORK) begin
            r_h_row[r_col] <= w_h;
            r_f_row[r_col] <= w_f;
        end else begin
            r_h_row[r_col] <= r_h_row[r_col];
        end
    end

`ifdef SW_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;
    assign o_cycle_count = r_cycle_count;

    // WORK-cycle counter, cleared on accept and held with the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_count <= 32'd0;
        end else if (w_accept) begin
            r_cycle_count <= 32'd0;
        end else if (r_state == ST_WORK) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end else begin
            r_cycle_count <= r_cycle_count;
        end
    end
`endif

endmodule
